bp_cce_alu_seq: RTL and testbench
=================================

BP_CCE_ALU_SEQ -- requirements
Module: bp_cce_alu_seq

Interface
REQ-001 Parameter: width_p, default 16, operand/result width; legal range 4..64.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 v_i  input  1  operation request valid.
REQ-005 ready_o  output  1  block can accept a request this cycle.
REQ-006 alu_op_i  input  4  opcode: 0 add, 1 sub, 2 lsh, 3 rsh, 4 ash, 5 and, 6 or, 7 xor, 8 neg, 9 not, 10 nand, 11 nor, 12 mul, 13-15 illegal.
REQ-007 opd_a_i, opd_b_i  input  width_p  operands.
REQ-008 v_o  output  1  result valid.
REQ-009 yumi_i  input  1  consumer takes result; legal only when v_o=1.
REQ-010 res_o  output  width_p  registered result.
REQ-011 zero_o  output  1  res_o == 0.
REQ-012 carry_o  output  1  add carry-out / sub borrow / mul overflow; 0 for all other ops.

Function
REQ-013 States: IDLE, MUL, DONE; ready_o = (state==IDLE) && !reset_i.
REQ-014 Accept occurs when v_i && ready_o; operands and opcode captured on that edge; inputs ignored otherwise.
REQ-015 IDLE, accept, op != mul: compute combinationally, register res_o/flags, go DONE; v_o=1 next cycle (latency 1).
REQ-016 IDLE, accept, op == mul: clear accumulator and counter, go MUL.
REQ-017 MUL: unsigned shift-add, one multiplier bit per cycle, LSB first; exactly width_p cycles in MUL, then DONE; total accept-to-v_o latency width_p+1 cycles.
REQ-018 mul: res_o = low width_p bits of the 2*width_p product; carry_o = 1 iff upper width_p bits nonzero.
REQ-019 DONE: v_o=1, res_o/flags held stable; yumi_i -> IDLE next cycle, v_o=0; no new accept in the yumi cycle (ready_o=0 in DONE).
REQ-020 add/sub: modulo 2^width_p; carry_o = carry-out of add, = 1 when opd_a < opd_b (unsigned) for sub.
REQ-021 lsh/rsh: logical shift of opd_a by full unsigned opd_b; opd_b >= width_p -> result 0.
REQ-022 ash: arithmetic right shift of opd_a (MSB sign); opd_b >= width_p -> all bits equal opd_a MSB.
REQ-023 and/or/xor bitwise; neg = bitwise ~opd_a; nand/nor bitwise ~(a&b), ~(a|b).
REQ-024 not: logical, res_o = 1 if opd_a == 0 else 0 (zero-extended).
REQ-025 Illegal opcode: accepted, completes as single-cycle op, res_o = 0, zero_o = 1, carry_o = 0.
REQ-026 zero_o computed from final registered res_o for every op including mul.
REQ-027 yumi_i while v_o=0 is ignored, no state change.
REQ-028 v_i held high across DONE is not accepted until state returns to IDLE.

Reset
REQ-029 reset_i=1 at an edge: state IDLE, v_o=0, res_o=0, zero_o=0, carry_o=0, mul accumulator/counter cleared.
REQ-030 Reset overrides all other inputs same edge, including accept and yumi_i; mid-MUL reset aborts with no v_o pulse.
REQ-031 ready_o=0 while reset_i=1; ready_o=1 first cycle after reset deasserts.

Verification (width_p=16)
REQ-032 add 0xFFFF + 0x0002 -> one cycle later v_o=1, res_o=0x0001, carry_o=1, zero_o=0; hold yumi_i=0 3 cycles -> outputs stable.
REQ-033 sub 0x0003 - 0x0005 -> res_o=0xFFFE, carry_o=1; ash 0x8000 by 20 -> res_o=0xFFFF; rsh 0x8000 by 16 -> res_o=0, zero_o=1.
REQ-034 mul 0x0100 * 0x0100 -> v_o exactly 17 cycles after accept, res_o=0x0000, carry_o=1, zero_o=1; mul 0x0012*0x0034 -> res_o=0x03A8, carry_o=0.
REQ-035 Back-to-back: v_i held high with op add, yumi_i asserted each DONE cycle -> one accept every 2 cycles, ready_o never high in DONE.
REQ-036 reset_i pulsed at cycle 5 of a mul -> next cycle v_o=0, res_o=0, ready_o=1; no result ever emitted for the aborted op.
REQ-037 opcode 14 with any operands -> res_o=0, zero_o=1, carry_o=0 after 1 cycle; not 0x0000 -> res_o=0x0001.

Source files
------------

// File: rtl/bp_cce_alu_seq.sv
// Sequential ALU. Most ops finish one cycle after accept. Multiply is an
// unsigned shift-add that retires one multiplier bit per cycle.
// The result is held in DONE until the consumer takes it with yumi_i.
module bp_cce_alu_seq #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [3:0]         alu_op_i,
    input  logic [width_p-1:0] opd_a_i,
    input  logic [width_p-1:0] opd_b_i,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] res_o,
    output logic               zero_o,
    output logic               carry_o
);

    localparam logic [3:0] op_mul_lp = 4'd12;
    localparam int cnt_w_lp = $clog2(width_p);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(width_p - 1);

    typedef enum logic [1:0] {
        E_IDLE,
        E_MUL,
        E_DONE
    } state_e;

    state_e state_r, state_n;

    logic                   accept;
    logic                   mul_last;
    logic [2*width_p-1:0]   mcand_r;
    logic [width_p-1:0]     mplier_r;
    logic [2*width_p-1:0]   acc_r;
    logic [2*width_p-1:0]   acc_nxt;
    logic [cnt_w_lp-1:0]    cnt_r;
    logic [width_p:0]       alu_res;

    // Single-cycle ops: returns {carry, result}; mul and illegal opcodes give zero.
    function automatic logic [width_p:0] alu_f(input logic [3:0]         op,
                                               input logic [width_p-1:0] a,
                                               input logic [width_p-1:0] b);
        logic [width_p-1:0]        y;
        logic                      c;
        logic signed [width_p-1:0] sa;
        logic                      big;
        y   = '0;
        c   = 1'b0;
        sa  = a;
        big = (b >= width_p'(width_p));
        case (op)
            4'd0:    {c, y} = {1'b0, a} + {1'b0, b};
            4'd1: begin
                y = a - b;
                c = (a < b);
            end
            4'd2:    y = big ? '0 : (a << b);
            4'd3:    y = big ? '0 : (a >> b);
            4'd4:    y = big ? {width_p{a[width_p-1]}} : width_p'(sa >>> b);
            4'd5:    y = a & b;
            4'd6:    y = a | b;
            4'd7:    y = a ^ b;
            4'd8:    y = ~a;
            4'd9:    y = {{(width_p-1){1'b0}}, (a == '0)};
            4'd10:   y = ~(a & b);
            4'd11:   y = ~(a | b);
            default: y = '0;
        endcase
        return {c, y};
    endfunction

    assign ready_o  = (state_r == E_IDLE) && !reset_i;
    assign v_o      = (state_r == E_DONE);
    assign accept   = v_i && ready_o;
    assign mul_last = (state_r == E_MUL) && (cnt_r == cnt_last_lp);
    assign acc_nxt  = acc_r + (mplier_r[0] ? mcand_r : '0);
    assign alu_res  = alu_f(alu_op_i, opd_a_i, opd_b_i);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= E_IDLE;
        else         state_r <= state_n;
    end

    // Next-state logic: IDLE -> MUL/DONE on accept, MUL -> DONE after the last bit, DONE -> IDLE on yumi.
    always_comb begin
        state_n = state_r;
        case (state_r)
            E_IDLE: if (accept) state_n = (alu_op_i == op_mul_lp) ? E_MUL : E_DONE;
            E_MUL:  if (mul_last) state_n = E_DONE;
            E_DONE: if (yumi_i) state_n = E_IDLE;
            default: state_n = E_IDLE;
        endcase
    end

    // Result, flags and the multiplier datapath.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            res_o    <= '0;
            zero_o   <= 1'b0;
            carry_o  <= 1'b0;
            acc_r    <= '0;
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else begin
            if (accept && alu_op_i != op_mul_lp) begin
                res_o   <= alu_res[width_p-1:0];
                carry_o <= alu_res[width_p];
                zero_o  <= (alu_res[width_p-1:0] == '0);
            end
            if (accept && alu_op_i == op_mul_lp) begin
                acc_r    <= '0;
                cnt_r    <= '0;
                mcand_r  <= {{width_p{1'b0}}, opd_a_i};
                mplier_r <= opd_b_i;
            end
            if (state_r == E_MUL) begin
                acc_r    <= acc_nxt;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r + cnt_w_lp'(1);
                if (mul_last) begin
                    res_o   <= acc_nxt[width_p-1:0];
                    carry_o <= |acc_nxt[2*width_p-1:width_p];
                    zero_o  <= (acc_nxt[width_p-1:0] == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_cce_alu_seq.sv
// Bench for bp_cce_alu_seq at width_p=16: behavioural model plus directed vectors.
module tb_bp_cce_alu_seq;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic        ready_o;
    logic [3:0]  alu_op_i = 4'd0;
    logic [15:0] opd_a_i = 16'h0;
    logic [15:0] opd_b_i = 16'h0;
    logic        v_o;
    logic        yumi_i = 1'b0;
    logic [15:0] res_o;
    logic        zero_o;
    logic        carry_o;

    int n_tests = 0;
    int n_fail  = 0;

    bp_cce_alu_seq #(.width_p(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .alu_op_i(alu_op_i), .opd_a_i(opd_a_i), .opd_b_i(opd_b_i),
        .v_o(v_o), .yumi_i(yumi_i), .res_o(res_o), .zero_o(zero_o), .carry_o(carry_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected {carry, result} from plain arithmetic on 32-bit integers.
    function automatic logic [16:0] model_f(input int op, input int unsigned a, input int unsigned b);
        int unsigned p;
        int signed   sa;
        case (op)
            0: begin p = a + b; return {p[16], p[15:0]}; end
            1: begin p = a - b; return {(a < b), p[15:0]}; end
            2: begin p = (b >= 16) ? 0 : (a << b); return {1'b0, p[15:0]}; end
            3: begin p = (b >= 16) ? 0 : (a >> b); return {1'b0, p[15:0]}; end
            4: begin
                sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
                if (b >= 16) p = (sa < 0) ? 32'hFFFF : 0;
                else         p = int'(sa >>> b);
                return {1'b0, p[15:0]};
            end
            5:  begin p = a & b;    return {1'b0, p[15:0]}; end
            6:  begin p = a | b;    return {1'b0, p[15:0]}; end
            7:  begin p = a ^ b;    return {1'b0, p[15:0]}; end
            8:  begin p = ~a;       return {1'b0, p[15:0]}; end
            9:  begin p = (a == 0) ? 1 : 0; return {1'b0, p[15:0]}; end
            10: begin p = ~(a & b); return {1'b0, p[15:0]}; end
            11: begin p = ~(a | b); return {1'b0, p[15:0]}; end
            12: begin p = a * b;    return {(p[31:16] != 0), p[15:0]}; end
            default: return 17'h0;
        endcase
    endfunction

    // Model state: idle / counting down / holding a result.
    bit          m_started = 0;
    bit          m_idle = 1;
    bit          m_valid = 0;
    int          m_wait = 0;
    logic [15:0] m_res = 0, m_pend_res = 0;
    logic        m_carry = 0, m_pend_carry = 0;

    always @(posedge clk_i) begin
        logic [16:0] r;
        m_started = 1;
        if (reset_i) begin
            m_idle = 1; m_valid = 0; m_wait = 0;
            m_res = 0; m_carry = 0;
        end else if (m_idle && v_i) begin
            r = model_f(int'(alu_op_i), int'(opd_a_i), int'(opd_b_i));
            m_pend_res = r[15:0]; m_pend_carry = r[16];
            m_idle = 0;
            m_wait = (alu_op_i == 4'd12) ? 16 : 0;
            if (m_wait == 0) begin
                m_valid = 1; m_res = m_pend_res; m_carry = m_pend_carry;
            end
        end else if (!m_idle && !m_valid) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1; m_res = m_pend_res; m_carry = m_pend_carry;
            end
        end else if (m_valid && yumi_i) begin
            m_valid = 0; m_idle = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk_i) begin
        if (m_started) begin
            chk("ready_o", 32'(ready_o), 32'(m_idle && !reset_i));
            chk("v_o", 32'(v_o), 32'(m_valid));
            if (m_valid) begin
                chk("res_o", 32'(res_o), 32'(m_res));
                chk("carry_o", 32'(carry_o), 32'(m_carry));
                chk("zero_o", 32'(zero_o), 32'(m_res == 16'h0));
            end
        end
    end

    // Issue one op from IDLE, wait for the result, hold it, then take it.
    task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold, output logic [15:0] r, output logic c,
                       output logic z, output int lat);
        int cyc;
        v_i = 1; alu_op_i = op; opd_a_i = a; opd_b_i = b;
        @(posedge clk_i); #1;
        v_i = 0; opd_a_i = 16'($urandom); opd_b_i = 16'($urandom); alu_op_i = 4'($urandom);
        cyc = 0;
        while (!v_o && cyc < 40) begin
            @(posedge clk_i); #1; cyc++;
        end
        if (!v_o) chk("result_timeout", 32'(v_o), 32'd1);
        lat = cyc + 1; r = res_o; c = carry_o; z = zero_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            chk("hold_res", 32'(res_o), 32'(r));
            chk("hold_vo", 32'(v_o), 32'd1);
        end
        yumi_i = 1;
        @(posedge clk_i); #1;
        yumi_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic        c, z;
        int          lat, accepts;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_vo", 32'(v_o), 0);
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_res", 32'(res_o), 0);
        chk("rst_zero", 32'(zero_o), 0);
        chk("rst_carry", 32'(carry_o), 0);
        reset_i = 0;
        #1;
        chk("ready_after_rst", 32'(ready_o), 1);

        // Add with carry, held three cycles
        run(4'd0, 16'hFFFF, 16'h0002, 3, r, c, z, lat);
        chk("add_lat", lat, 1);
        chk("add_res", 32'(r), 32'h0001);
        chk("add_carry", 32'(c), 1);
        chk("add_zero", 32'(z), 0);

        run(4'd1, 16'h0003, 16'h0005, 0, r, c, z, lat);
        chk("sub_res", 32'(r), 32'hFFFE);
        chk("sub_borrow", 32'(c), 1);
        run(4'd4, 16'h8000, 16'd20, 0, r, c, z, lat);
        chk("ash_big", 32'(r), 32'hFFFF);
        run(4'd3, 16'h8000, 16'd16, 0, r, c, z, lat);
        chk("rsh_big", 32'(r), 0);
        chk("rsh_zero", 32'(z), 1);

        // Multiplies
        run(4'd12, 16'h0100, 16'h0100, 0, r, c, z, lat);
        chk("mul_lat", lat, 17);
        chk("mul_res", 32'(r), 0);
        chk("mul_ovf", 32'(c), 1);
        chk("mul_zero", 32'(z), 1);
        run(4'd12, 16'h0012, 16'h0034, 0, r, c, z, lat);
        chk("mul2_res", 32'(r), 32'h03A8);
        chk("mul2_carry", 32'(c), 0);
        run(4'd12, 16'hFFFF, 16'hFFFF, 0, r, c, z, lat);
        chk("mul3_res", 32'(r), 32'h0001);
        chk("mul3_carry", 32'(c), 1);

        // Illegal opcode and logical not
        run(4'd14, 16'hA5A5, 16'h5A5A, 0, r, c, z, lat);
        chk("ill_lat", lat, 1);
        chk("ill_res", 32'(r), 0);
        chk("ill_zero", 32'(z), 1);
        chk("ill_carry", 32'(c), 0);
        run(4'd9, 16'h0000, 16'h1234, 0, r, c, z, lat);
        chk("not0_res", 32'(r), 32'h0001);
        run(4'd9, 16'h0005, 16'h0000, 0, r, c, z, lat);
        chk("not5_res", 32'(r), 0);

        // Remaining ops, checked by the model
        run(4'd2, 16'h00F1, 16'd4, 0, r, c, z, lat);
        chk("lsh_res", 32'(r), 32'h0F10);
        run(4'd4, 16'h8010, 16'd4, 0, r, c, z, lat);
        chk("ash_res", 32'(r), 32'hF801);
        run(4'd5,  16'hF0F0, 16'hFF00, 0, r, c, z, lat);
        run(4'd6,  16'hF0F0, 16'h0F00, 0, r, c, z, lat);
        run(4'd7,  16'hF0F0, 16'hFF00, 0, r, c, z, lat);
        run(4'd8,  16'h1234, 16'h0000, 0, r, c, z, lat);
        chk("neg_res", 32'(r), 32'hEDCB);
        run(4'd10, 16'hFFFF, 16'hFFFF, 0, r, c, z, lat);
        run(4'd11, 16'h0F0F, 16'h00F0, 0, r, c, z, lat);
        run(4'd2,  16'h0001, 16'd16, 0, r, c, z, lat);
        run(4'd1,  16'h0005, 16'h0005, 0, r, c, z, lat);

        // yumi_i with nothing valid is ignored
        yumi_i = 1;
        @(posedge clk_i); #1;
        yumi_i = 0;
        chk("stray_yumi_ready", 32'(ready_o), 1);

        // Back-to-back adds, consumer takes each result immediately
        accepts = 0;
        v_i = 1; alu_op_i = 4'd0; opd_a_i = 16'h0001; opd_b_i = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (v_i && ready_o) accepts++;
            chk("b2b_ready_in_done", 32'(ready_o && v_o), 0);
            @(posedge clk_i); #1;
            yumi_i = v_o;
        end
        v_i = 0; yumi_i = 0;
        chk("b2b_accepts", accepts, 5);
        if (v_o) begin
            yumi_i = 1; @(posedge clk_i); #1; yumi_i = 0;
        end

        // Reset in the middle of a multiply
        v_i = 1; alu_op_i = 4'd12; opd_a_i = 16'h0012; opd_b_i = 16'h0034;
        @(posedge clk_i); #1;
        v_i = 0;
        repeat (4) begin @(posedge clk_i); #1; end
        reset_i = 1;
        @(posedge clk_i); #1;
        reset_i = 0;
        #1;
        chk("abort_vo", 32'(v_o), 0);
        chk("abort_res", 32'(res_o), 0);
        chk("abort_ready", 32'(ready_o), 1);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk_i); #1;
            chk("abort_no_result", 32'(v_o), 0);
        end

        // A normal op still works after the abort
        run(4'd0, 16'h1234, 16'h4321, 0, r, c, z, lat);
        chk("post_abort_add", 32'(r), 32'h5555);

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
